// File: rtl/io_pkg.sv
// Shared memory-mapped IO definitions: register addresses, data width and read-select codes.
// The CPU IO mux imports the same addresses so both sides decode identically.
package io_pkg;

    localparam int IO_DATA_W = 16;

    localparam logic [31:0] LED_ADDR = 32'hFFFF_FC60;
    localparam logic [31:0] SW_ADDR  = 32'hFFFF_FC70;
    localparam logic [31:0] BTN_ADDR = 32'hFFFF_FC74;

    // 10 ms at 100 MHz
    localparam int unsigned DEBOUNCE_CYC_DEFAULT = 1_000_000;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_SW,
        RD_BTN
    } rd_sel_e;

    function automatic logic addr_hit(input logic cs, input logic [31:0] addr,
                                      input logic [31:0] target);
        return cs && (addr == target);
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchronizer followed by a stability counter; the output only follows the
// synchronized input after it has held one value for DEBOUNCE_CYC consecutive cycles.
module io_debounce #(
    parameter int          WIDTH        = 16,
    parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [WIDTH-1:0] sync_1;
    logic [WIDTH-1:0] sync_2;
    logic [WIDTH-1:0] sync_prev;
    logic [CNT_W-1:0] count;

    // sync_prev lets a new candidate value restart the count even while it still differs from stable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_1    <= '0;
            sync_2    <= '0;
            sync_prev <= '0;
            stable    <= '0;
            count     <= '0;
        end else begin
            sync_1    <= raw;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
            if (sync_2 == stable) begin
                count <= '0;
            end else if (sync_2 != sync_prev) begin
                count <= CNT_W'(1);
            end else if (count >= CNT_LAST) begin
                stable <= sync_2;
                count  <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mmio_device.sv
// Peripheral side of the CPU memory-mapped IO path: LED register, debounced switches,
// and a sticky button-press flag that is cleared by reading it.
module mmio_device
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 led_cs,
    input  logic                 sw_cs,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    output logic [IO_DATA_W-1:0] rdata,
    input  logic [IO_DATA_W-1:0] switch_raw,
    input  logic                 btn_raw,
    output logic [IO_DATA_W-1:0] led_out
);

    logic [IO_DATA_W-1:0] sw_stable;
    logic                 btn_stable;
    logic                 btn_prev;
    logic                 btn_flag;
    logic                 btn_clear;
    rd_sel_e              rd_sel;
    logic                 unused_wdata_hi;

    assign unused_wdata_hi = ^wdata[31:16];

    io_debounce #(.WIDTH(IO_DATA_W), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_sw_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (switch_raw),
        .stable (sw_stable)
    );

    io_debounce #(.WIDTH(1), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (btn_raw),
        .stable (btn_stable)
    );

    assign btn_clear = addr_hit(sw_cs, addr, BTN_ADDR);

    // A press arriving in the same cycle as a clearing read takes priority so it is never lost
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_out  <= '0;
            btn_prev <= 1'b0;
            btn_flag <= 1'b0;
        end else begin
            if (addr_hit(led_cs, addr, LED_ADDR)) begin
                led_out <= wdata[IO_DATA_W-1:0];
            end
            btn_prev <= btn_stable;
            if (btn_stable && !btn_prev) begin
                btn_flag <= 1'b1;
            end else if (btn_clear) begin
                btn_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_sel = RD_NONE;
        if (addr_hit(sw_cs, addr, SW_ADDR)) begin
            rd_sel = RD_SW;
        end else if (btn_clear) begin
            rd_sel = RD_BTN;
        end
    end

    always_comb begin
        rdata = '0;
        case (rd_sel)
            RD_SW:   rdata = sw_stable;
            RD_BTN:  rdata = {{(IO_DATA_W-1){1'b0}}, btn_flag};
            default: rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_mmio_device.sv
// Directed-vector bench for mmio_device with the debounce window shortened to 8 cycles.
`timescale 1ns/1ps
module tb_mmio_device;
    import io_pkg::*;

    localparam int unsigned DEB = 8;

    logic        clk;
    logic        rst_n;
    logic        led_cs;
    logic        sw_cs;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [15:0] rdata;
    logic [15:0] switch_raw;
    logic        btn_raw;
    logic [15:0] led_out;

    int vector_count    = 0;
    int miscompare_count = 0;

    mmio_device #(.DEBOUNCE_CYC(DEB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .led_cs     (led_cs),
        .sw_cs      (sw_cs),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .switch_raw (switch_raw),
        .btn_raw    (btn_raw),
        .led_out    (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic l_cs, input logic s_cs,
                                 input logic [31:0] a, input logic [31:0] wd);
        led_cs = l_cs;
        sw_cs  = s_cs;
        addr   = a;
        wdata  = wd;
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bound on total run time in case the stimulus ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        switch_raw = 16'hFFFF;
        btn_raw    = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        tick(3);
        checkOutput("rst_led", led_out, 16'h0000);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, BTN_ADDR, 32'h0);
        checkOutput("rst_btn_rd", rdata, 16'h0000);
        applyStimulus(1'b0, 1'b1, SW_ADDR, 32'h0);
        checkOutput("rst_sw_rd", rdata, 16'h0000);
        tick(9);
        checkOutput("sw_ffff_early", rdata, 16'h0000);
        tick(1);
        checkOutput("sw_ffff_accept", rdata, 16'hFFFF);

        applyStimulus(1'b1, 1'b0, LED_ADDR, 32'hABCD_1234);
        checkOutput("led_before_edge", led_out, 16'h0000);
        tick(1);
        checkOutput("led_write", led_out, 16'h1234);
        applyStimulus(1'b1, 1'b0, 32'hFFFF_FC64, 32'h0);
        tick(1);
        checkOutput("led_wrong_addr", led_out, 16'h1234);
        applyStimulus(1'b1, 1'b1, LED_ADDR, 32'h0000_5A5A);
        checkOutput("led_addr_read", rdata, 16'h0000);
        tick(1);
        checkOutput("led_dual_cs", led_out, 16'h5A5A);
        applyStimulus(1'b0, 1'b0, SW_ADDR, 32'h0);
        checkOutput("sw_no_cs", rdata, 16'h0000);

        switch_raw = 16'h0000;
        applyStimulus(1'b0, 1'b1, SW_ADDR, 32'h0);
        tick(12);
        checkOutput("sw_zero", rdata, 16'h0000);
        for (int seg = 0; seg < 10; seg++) begin
            switch_raw = (seg % 2 == 0) ? 16'h00FF : 16'h0000;
            for (int c = 0; c < 3; c++) begin
                tick(1);
                checkOutput($sformatf("sw_bounce_%0d_%0d", seg, c), rdata, 16'h0000);
            end
        end
        switch_raw = 16'h00FF;
        tick(9);
        checkOutput("sw_settle_early", rdata, 16'h0000);
        tick(1);
        checkOutput("sw_settle_accept", rdata, 16'h00FF);

        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        btn_raw = 1'b1;
        tick(12);
        btn_raw = 1'b0;
        applyStimulus(1'b0, 1'b1, BTN_ADDR, 32'h0);
        checkOutput("btn_press", rdata, 16'h0001);
        tick(1);
        checkOutput("btn_cleared", rdata, 16'h0000);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        tick(14);
        applyStimulus(1'b0, 1'b1, BTN_ADDR, 32'h0);
        checkOutput("btn_release", rdata, 16'h0000);

        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        btn_raw = 1'b1;
        tick(10);
        applyStimulus(1'b0, 1'b1, BTN_ADDR, 32'h0);
        checkOutput("btn_pre_rise", rdata, 16'h0000);
        tick(1);
        checkOutput("btn_set_wins", rdata, 16'h0001);
        tick(1);
        checkOutput("btn_clear_after", rdata, 16'h0000);
        btn_raw = 1'b0;

        applyStimulus(1'b0, 1'b1, SW_ADDR, 32'h0);
        switch_raw = 16'h0F0F;
        tick(7);
        checkOutput("sw_midcount", rdata, 16'h00FF);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_mid_sw", rdata, 16'h0000);
        checkOutput("rst_mid_led", led_out, 16'h0000);
        tick(9);
        checkOutput("rst_mid_early", rdata, 16'h0000);
        tick(1);
        checkOutput("rst_mid_accept", rdata, 16'h0F0F);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule
